// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg : skid state encoding, per-stage bundle widths, field offsets.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int IF_ID_CTRL_W  = 8;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 24;
    localparam int ID_EX_DATA_W  = 175;
    localparam int EX_MEM_CTRL_W = 12;
    localparam int EX_MEM_DATA_W = 101;
    localparam int MEM_WB_CTRL_W = 4;
    localparam int MEM_WB_DATA_W = 69;

    // ID/EX control bundle, LSB first; bit 23 is spare
    localparam int IDEX_C_WEN_RF   = 0;
    localparam int IDEX_C_ALU_LSB  = 1;
    localparam int IDEX_C_MEM_LSB  = 5;
    localparam int IDEX_C_F3_LSB   = 7;
    localparam int IDEX_C_WB_LSB   = 10;
    localparam int IDEX_C_BRANCH   = 12;
    localparam int IDEX_C_JUMP     = 13;
    localparam int IDEX_C_PHT_LSB  = 14;
    localparam int IDEX_C_PREDICT  = 22;

    // ID/EX data bundle, LSB first
    localparam int IDEX_D_RS2_LSB    = 0;
    localparam int IDEX_D_RS1_LSB    = 5;
    localparam int IDEX_D_RD_LSB     = 10;
    localparam int IDEX_D_PCNXT_LSB  = 15;
    localparam int IDEX_D_PCCUR_LSB  = 47;
    localparam int IDEX_D_EXT_LSB    = 79;
    localparam int IDEX_D_RDATA2_LSB = 111;
    localparam int IDEX_D_RDATA1_LSB = 143;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_skid_ctrl : 2-entry skid state machine, registered ready, load/clear. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic in_valid_i,
    input  logic out_ready_i,
    output logic in_ready_o,
    output logic out_valid_o,
    output logic load_main_o,
    output logic main_from_skid_o,
    output logic load_skid_o,
    output logic clear_o
);

    skid_state_e state_q, state_d;
    logic        in_ready_q;
    logic        xfer_in;
    logic        xfer_out;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = in_ready_q;
    assign xfer_in     = in_valid_i & in_ready_q;
    assign xfer_out    = out_valid_o & out_ready_i;

    always_comb begin
        state_d          = state_q;
        load_main_o      = 1'b0;
        main_from_skid_o = 1'b0;
        load_skid_o      = 1'b0;
        clear_o          = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
            clear_o = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d     = ST_ONE;
                        load_main_o = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        load_main_o = 1'b1;
                    end else if (xfer_in) begin
                        state_d     = ST_FULL;
                        load_skid_o = 1'b1;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        state_d          = ST_ONE;
                        load_main_o      = 1'b1;
                        main_from_skid_o = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // ready is a flop decoded from the next state, so out_ready never reaches in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_skid : inter-stage register with 2-entry skid and flush.        |
// | Option PIPE_STAGE_PERF_EN adds stall/bubble/flush counters. Revision : 1.0 |
// +----------------------------------------------------------------------------+
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = ID_EX_CTRL_W,
    parameter int DATA_W     = ID_EX_DATA_W,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;
    logic              clear;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;

    pipe_skid_ctrl u_ctrl (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush),
        .in_valid_i       (in_valid),
        .out_ready_i      (out_ready),
        .in_ready_o       (in_ready),
        .out_valid_o      (out_valid),
        .load_main_o      (load_main),
        .main_from_skid_o (main_from_skid),
        .load_skid_o      (load_skid),
        .clear_o          (clear)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else if (clear) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (load_main) main_ctrl_q <= main_from_skid ? skid_ctrl_q : in_ctrl;
            if (load_skid) skid_ctrl_q <= in_ctrl;
        end
    end

    if (CLEAR_DATA) begin : g_clear_data
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end else if (clear) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end else begin
                if (load_main) main_data_q <= main_from_skid ? skid_data_q : in_data;
                if (load_skid) skid_data_q <= in_data;
            end
        end
    end else begin : g_keep_data
        // flush leaves stale data in place; the zeroed ctrl already marks it dead
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end else begin
                if (load_main) main_data_q <= main_from_skid ? skid_data_q : in_data;
                if (load_skid) skid_data_q <= in_data;
            end
        end
    end

    assign out_ctrl = out_valid ? main_ctrl_q : '0;
    assign out_data = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt_q  <= sat_inc32(stall_cnt_q);
            if (!out_valid)              bubble_cnt_q <= sat_inc32(bubble_cnt_q);
            if (flush && out_valid)      flush_cnt_q  <= sat_inc32(flush_cnt_q);
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_stage_skid : scoreboard bench, CLEAR_DATA=1 and CLEAR_DATA=0 DUTs. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CW = ID_EX_CTRL_W;
    localparam int DW = ID_EX_DATA_W;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl   = '0;
    logic [DW-1:0] in_data   = '0;

    logic          in_ready_c, out_valid_c, in_ready_k, out_valid_k;
    logic [CW-1:0] out_ctrl_c, out_ctrl_k;
    logic [DW-1:0] out_data_c, out_data_k;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_c, bubble_c, flsh_c, stall_k, bubble_k, flsh_k;
    logic [31:0]   stall_m = '0, bubble_m = '0, flsh_m = '0;
`endif

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
        .out_ctrl(out_ctrl_c), .out_data(out_data_c)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall_cnt(stall_c), .perf_bubble_cnt(bubble_c), .perf_flush_cnt(flsh_c)
`endif
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) dut_k (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_k),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_k), .out_ready(out_ready),
        .out_ctrl(out_ctrl_k), .out_data(out_data_k)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall_cnt(stall_k), .perf_bubble_cnt(bubble_k), .perf_flush_cnt(flsh_k)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } entry_t;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Monitor: the stage must behave as a 2-deep FIFO whose ready reflects occupancy
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_c", DW'(in_ready_c), DW'(sb.size() < 2));
            check("in_ready_k", DW'(in_ready_k), DW'(sb.size() < 2));
            check("out_valid_c", DW'(out_valid_c), DW'(sb.size() != 0));
            check("out_valid_k", DW'(out_valid_k), DW'(sb.size() != 0));
            if (sb.size() == 0) begin
                check("bubble_ctrl_c", DW'(out_ctrl_c), '0);
                check("bubble_ctrl_k", DW'(out_ctrl_k), '0);
            end
`ifdef PIPE_STAGE_PERF_EN
            check("perf_stall_c", DW'(stall_c), DW'(stall_m));
            check("perf_bubble_c", DW'(bubble_c), DW'(bubble_m));
            check("perf_flush_c", DW'(flsh_c), DW'(flsh_m));
            check("perf_stall_k", DW'(stall_k), DW'(stall_m));
            if (sb.size() != 0 && !out_ready) stall_m = stall_m + 1;
            if (sb.size() == 0)               bubble_m = bubble_m + 1;
            if (flush && sb.size() != 0)      flsh_m = flsh_m + 1;
`endif
            if (out_valid_c) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got ctrl %h expected no entry", out_ctrl_c);
                end else begin
                    check("out_ctrl_c", DW'(out_ctrl_c), DW'(sb[0].c));
                    check("out_data_c", out_data_c, sb[0].d);
                    check("out_ctrl_k", DW'(out_ctrl_k), DW'(sb[0].c));
                    check("out_data_k", out_data_k, sb[0].d);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    // Drive one cycle's inputs; acceptance is decided from model occupancy
    task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        logic rdy_m;
        entry_t e;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rdy_m     = (sb.size() < 2);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else if (iv && rdy_m) begin
            e.c = c;
            e.d = d;
            sb.push_back(e);
        end
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", DW'(out_valid_c), '0);
        check("rst_in_ready", DW'(in_ready_c), DW'(1'b1));
        check("rst_out_ctrl", DW'(out_ctrl_c), '0);
        check("rst_out_data_k", out_data_k, '0);
        rst_n = 1'b1;

        // streaming at full rate
        for (int i = 1; i <= 8; i++) step(1'b1, CW'(i), rnd_data(), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // stall into FULL, then release
        step(1'b1, CW'(24'h11), rnd_data(), 1'b0, 1'b0);
        step(1'b1, CW'(24'h22), rnd_data(), 1'b0, 1'b0);
        check("full_in_ready", DW'(in_ready_c), '0);
        step(1'b1, CW'(24'h99), rnd_data(), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // flush in FULL with a competing input
        step(1'b1, CW'(24'h11), DW'(16'hDEAD), 1'b0, 1'b0);
        step(1'b1, CW'(24'h22), DW'(16'hBEEF), 1'b0, 1'b0);
        step(1'b1, CW'(24'h33), DW'(16'h3333), 1'b0, 1'b1);
        check("flush_valid", DW'(out_valid_c), '0);
        check("flush_ready", DW'(in_ready_c), DW'(1'b1));
        check("flush_ctrl_k", DW'(out_ctrl_k), '0);
        check("flush_keep_data", out_data_k, DW'(16'hDEAD));
        check("flush_clear_data", out_data_c, '0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // asynchronous reset while FULL
        step(1'b1, CW'(24'h44), rnd_data(), 1'b0, 1'b0);
        step(1'b1, CW'(24'h45), rnd_data(), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", DW'(out_valid_c), '0);
        check("arst_in_ready", DW'(in_ready_k), DW'(1'b1));
        check("arst_out_ctrl", DW'(out_ctrl_k), '0);
        check("arst_data_c", out_data_c, '0);
        check("arst_data_k", out_data_k, '0);
        rst_n = 1'b1;
        sb.delete();
`ifdef PIPE_STAGE_PERF_EN
        stall_m = '0; bubble_m = '0; flsh_m = '0;
`endif
        step(1'b1, CW'(24'h55), rnd_data(), 1'b1, 1'b0);
        check("post_rst_valid", DW'(out_valid_c), DW'(1'b1));
        check("post_rst_ctrl", DW'(out_ctrl_c), DW'(24'h55));

        // idle, stall and flush pattern for the counters
        step(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, CW'(24'h66), rnd_data(), 1'b0, 1'b0);
        repeat (4) step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, CW'($urandom()), rnd_data(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);
        check("drained", DW'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
